async_up_counter: RTL and testbench
===================================

// Module: async_up_counter
//
// PURPOSE
//   Free-running binary up-counter: one clock, asynchronous active-high reset.
//   Increments by STEP on every rising clock edge and wraps modulo (MAX_COUNT+1).
//   Also reports terminal count and a one-cycle wrap pulse.
//   Used as a generic event/cycle counter or a timebase for downstream logic.
//
// PARAMETERS
//   WIDTH        8              counter width in bits
//   MAX_COUNT    2**WIDTH-1     last value before wrap; must be >= RESET_VALUE, < 2**WIDTH
//   RESET_VALUE  0              value loaded by reset and on wrap
//   STEP         1              increment per clock; must be >= 1 and <= MAX_COUNT
//
// PORTS
//   clk     in   1      single clock, rising-edge active
//   areset  in   1      reset: asynchronous, active-high
//   out     out  WIDTH  current count (registered)
//   tc      out  1      terminal count: 1 while out == MAX_COUNT (decoded from the register)
//   wrap    out  1      registered; 1 for exactly the cycle after out wrapped
//   Port order is fixed: clk, areset, out, tc, wrap.
//   tc and wrap are optional connections; three-port positional instantiation must work.
//
// BEHAVIOUR
//   - Reset (areset=1): out=RESET_VALUE, wrap=0, and tc reflects RESET_VALUE.
//     All of these take effect immediately, with no clock edge required.
//   - Reset is level-held: the outputs stay at the reset values for as long as areset=1.
//   - No internal reset synchronizer. The first increment happens on the first rising
//     clk edge after areset falls. The integrator must meet recovery/removal timing.
//   - Each rising clk with areset=0:
//       if (out > MAX_COUNT-STEP): out <= RESET_VALUE, wrap <= 1
//       else:                      out <= out+STEP,    wrap <= 0
//   - Arithmetic: unsigned, WIDTH bits.
//     Compute the comparison so that it can never overflow (no WIDTH+1 carry surprises).
//   - With defaults the counter runs 0,1,...,255,0,...; wrap is high in the cycle out=0.
//   - tc is combinational from out only (no input-to-output path).
//   - Latency: out changes one clock after each edge; there is no enable and no stall.
//   - Reset vs clock: if areset rises in the same instant as a clk edge, reset wins.
//   - Reset asserted mid-cycle (between edges) clears out at once.
//     It does not wait for an edge.
//   - There are no X states. Every flop is async-reset.
//   - Parameter violations are a static elaboration error (fatal assertion).
//
// TESTING (clk period 10 ns, defaults unless stated)
//   1. areset=1 for 70 ns while clk toggles -> out=0, tc=0, wrap=0 throughout.
//   2. Release areset, run 10 edges -> out=10. Then pulse areset high for 5 ns
//      between edges -> out=0 immediately, before the next edge.
//   3. Count from 0 for 255 edges -> out=255, tc=1.
//      Next edge -> out=0, wrap=1 for one cycle. Following edge -> out=1, wrap=0.
//   4. MAX_COUNT=9 -> sequence 0..9 with tc=1 at 9. Then 0 with wrap=1. Period is 10 clocks.
//   5. STEP=3, MAX_COUNT=10 -> 0,3,6,9, then 0 with wrap=1.
//      This checks the non-overflowing wrap compare.
//   6. Raise areset coincident with a clk edge while out=255 -> out=0, wrap=0.
//      The wrap pulse is suppressed.

Source files
------------

// File: rtl/async_up_counter.sv
// Free-running modulo (MAX_COUNT+1) up-counter stepping by STEP, with terminal-count decode and a wrap pulse.
// out and wrap are registered (one clock after each edge); tc is decoded from the register; no enable, no stall.
module async_up_counter #(
  parameter int WIDTH       = 8,
  parameter int MAX_COUNT   = 2**WIDTH-1,
  parameter int RESET_VALUE = 0,
  parameter int STEP        = 1
) (
  input  logic             clk,
  input  logic             areset,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1 || WIDTH > 31 ||
      longint'(MAX_COUNT) >= (longint'(1) << WIDTH) ||
      RESET_VALUE < 0 || MAX_COUNT < RESET_VALUE ||
      STEP < 1 || STEP > MAX_COUNT) begin : g_bad_params
    $fatal(1, "async_up_counter: illegal parameter combination");
  end

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
  // Comparing against MAX_COUNT-STEP (a constant) keeps the wrap test free of carry-out.
  localparam logic [WIDTH-1:0] THRESH = WIDTH'(MAX_COUNT - STEP);

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    out_d  = out_q + STEP_V;
    wrap_d = 1'b0;
    if (out_q > THRESH) begin
      out_d  = RST_V;
      wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      out_q  <= RST_V;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = out_q;
  assign tc   = (out_q == MAX_V);
  assign wrap = wrap_q;

endmodule

// File: tb/tb_async_up_counter.sv
// Directed bench for async_up_counter: default, MAX_COUNT=9 and STEP=3/MAX_COUNT=10 instances.
module tb_async_up_counter;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       areset_m9 = 1'b1;
  logic       areset_s3 = 1'b1;
  logic [7:0] out, out_m9, out_s3;
  logic       tc, tc_m9, tc_s3;
  logic       wrap, wrap_m9, wrap_s3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  async_up_counter dut (
    .clk(clk), .areset(areset), .out(out), .tc(tc), .wrap(wrap)
  );

  async_up_counter #(.MAX_COUNT(9)) dut_m9 (
    .clk(clk), .areset(areset_m9), .out(out_m9), .tc(tc_m9), .wrap(wrap_m9)
  );

  async_up_counter #(.MAX_COUNT(10), .STEP(3)) dut_s3 (
    .clk(clk), .areset(areset_s3), .out(out_s3), .tc(tc_s3), .wrap(wrap_s3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [7:0] s3_out [0:4];
  logic       s3_wrap[0:4];

  initial begin
    s3_out[0] = 8'd3; s3_out[1] = 8'd6; s3_out[2] = 8'd9; s3_out[3] = 8'd0; s3_out[4] = 8'd3;
    s3_wrap[0] = 1'b0; s3_wrap[1] = 1'b0; s3_wrap[2] = 1'b0; s3_wrap[3] = 1'b1; s3_wrap[4] = 1'b0;

    // Reset held across several clock edges
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_tc", 32'(tc), 32'd0);
      chk("rst_wrap", 32'(wrap), 32'd0);
    end

    // Release and count 10 edges, then a mid-cycle reset pulse
    areset = 1'b0;
    chk("post_release_out", 32'(out), 32'd0);
    repeat (10) @(posedge clk);
    #2;
    chk("count10_out", 32'(out), 32'd10);
    areset = 1'b1;
    #1;
    chk("midcycle_rst_out", 32'(out), 32'd0);
    chk("midcycle_rst_wrap", 32'(wrap), 32'd0);
    #4;
    areset = 1'b0;

    // Full-range count and wrap
    repeat (255) @(posedge clk);
    #1;
    chk("cnt255_out", 32'(out), 32'd255);
    chk("cnt255_tc", 32'(tc), 32'd1);
    chk("cnt255_wrap", 32'(wrap), 32'd0);
    @(posedge clk);
    #1;
    chk("wrap_out", 32'(out), 32'd0);
    chk("wrap_pulse", 32'(wrap), 32'd1);
    chk("wrap_tc", 32'(tc), 32'd0);
    @(posedge clk);
    #1;
    chk("after_wrap_out", 32'(out), 32'd1);
    chk("after_wrap_pulse", 32'(wrap), 32'd0);

    // Reset coincident with the edge that would wrap
    repeat (254) @(posedge clk);
    #1;
    chk("pre_coinc_out", 32'(out), 32'd255);
    @(posedge clk);
    areset = 1'b1;
    #1;
    chk("coinc_out", 32'(out), 32'd0);
    chk("coinc_wrap", 32'(wrap), 32'd0);
    chk("coinc_tc", 32'(tc), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("held_rst_out", 32'(out), 32'd0);
    chk("held_rst_wrap", 32'(wrap), 32'd0);
    areset = 1'b0;

    // MAX_COUNT = 9: period of 10 clocks
    chk("m9_rst_out", 32'(out_m9), 32'd0);
    areset_m9 = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      chk("m9_out", 32'(out_m9), 32'(i));
      chk("m9_tc", 32'(tc_m9), (i == 9) ? 32'd1 : 32'd0);
      chk("m9_wrap", 32'(wrap_m9), 32'd0);
    end
    @(posedge clk);
    #1;
    chk("m9_wrap_out", 32'(out_m9), 32'd0);
    chk("m9_wrap_pulse", 32'(wrap_m9), 32'd1);
    @(posedge clk);
    #1;
    chk("m9_after_out", 32'(out_m9), 32'd1);
    chk("m9_after_wrap", 32'(wrap_m9), 32'd0);

    // STEP = 3, MAX_COUNT = 10: 0,3,6,9,0,3
    @(negedge clk);
    areset_s3 = 1'b0;
    chk("s3_start_out", 32'(out_s3), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("s3_out", 32'(out_s3), 32'(s3_out[i]));
      chk("s3_wrap", 32'(wrap_s3), 32'(s3_wrap[i]));
      chk("s3_tc", 32'(tc_s3), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
